// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for pipe_stage_reg: occupancy/state encoding and the NOP bubble.
package pipe_stage_reg_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional 2-entry skid buffer. The occupancy state is exported on occ.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned     W      = 32,
   parameter int unsigned     SKID   = 1,
   parameter logic [W-1:0]    BUBBLE = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   occ
);

   // Handshake: a beat moves on an edge where valid & ready are both high;
   // acc is the upstream transfer, fire the downstream one. Flush overrides both.
   logic         acc;
   logic         fire;
   occ_e         state_q, state_d;
   logic [W-1:0] main_q, main_d;

   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occ       = state_q;
   assign acc       = in_valid & in_ready;
   assign fire      = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= BUBBLE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic [W-1:0] skid_q, skid_d;

         // in_ready depends only on registered state: no in->out timing path.
         assign in_ready = (state_q != TWO);

         always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            if (flush) begin
               state_d = EMPTY;
               main_d  = BUBBLE;
               skid_d  = BUBBLE;
            end else begin
               case (state_q)
                  EMPTY: begin
                     if (acc) begin
                        state_d = ONE;
                        main_d  = in_data;
                     end
                  end
                  ONE: begin
                     if (acc && fire) begin
                        main_d  = in_data;
                     end else if (acc) begin
                        state_d = TWO;
                        skid_d  = in_data;
                     end else if (fire) begin
                        state_d = EMPTY;
                     end
                  end
                  TWO: begin
                     if (fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                     end
                  end
                  default: state_d = EMPTY;
               endcase
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               skid_q <= BUBBLE;
            end else begin
               skid_q <= skid_d;
            end
         end
      end else begin : g_single
         assign in_ready = ~out_valid | out_ready;

         always_comb begin
            state_d = state_q;
            main_d  = main_q;
            if (flush) begin
               state_d = EMPTY;
               main_d  = BUBBLE;
            end else begin
               case (state_q)
                  EMPTY: begin
                     if (acc) begin
                        state_d = ONE;
                        main_d  = in_data;
                     end
                  end
                  ONE: begin
                     // With a single entry, acc while full implies fire.
                     if (acc) begin
                        main_d  = in_data;
                     end else if (fire) begin
                        state_d = EMPTY;
                     end
                  end
                  default: state_d = EMPTY;
               endcase
            end
         end
      end
   endgenerate

endmodule
